// File: rtl/cpa_pipe.sv
// cpa_pipe: pipelined final carry-propagate adder for the Wallace tree
// multiplier. The W-bit add is cut into SEG segments of SW = W/SEG bits,
// one segment per stage, with a valid/ready handshake on both sides and
// per-stage bubble collapsing.
// Optional feature macro: CPA_OVF_EN -- when defined, out_ovf_o reports
// signed two's-complement overflow; when undefined it is tied to 0.
module cpa_pipe #(
  parameter int W   = 16,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_a_i,
  input  logic [W-1:0] in_b_i,
  input  logic         in_cin_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_sum_o,
  output logic         out_cout_o,
  output logic         out_ovf_o
);

  localparam int SW = W / SEG;

  // Chains indexed by stage boundary: index 0 is the upstream input,
  // index k+1 is the register output of stage k.
  logic [SEG-1:0] acc_s;
  logic [SEG:0]   v_s;
  logic [SEG:0]   c_s;
  logic [W-1:0]   sum_s [SEG+1];
  logic [W-1:0]   a_s   [SEG];
  logic [W-1:0]   b_s   [SEG];
  logic           ovf_s;

  assign v_s[0]   = in_valid_i;
  assign c_s[0]   = in_cin_i;
  assign sum_s[0] = '0;
  assign a_s[0]   = in_a_i;
  assign b_s[0]   = in_b_i;

  // Accept chain: a stage can load when it is empty or its successor loads.
  always_comb begin
    acc_s        = '0;
    acc_s[SEG-1] = !v_s[SEG] || out_ready_i;
    for (int k = SEG - 2; k >= 0; k--) begin
      acc_s[k] = !v_s[k+1] || acc_s[k+1];
    end
  end

  for (genvar k = 0; k < SEG; k++) begin : g_stage
    logic [SW:0]  seg_s;
    logic [W-1:0] sum_d;
    logic         v_q;
    logic         c_q;
    logic [W-1:0] sum_q;

    // Segment k of both operands plus the carry arriving from below.
    assign seg_s = {1'b0, a_s[k][k*SW +: SW]} + {1'b0, b_s[k][k*SW +: SW]}
                 + {{SW{1'b0}}, c_s[k]};

    // Merge the new segment into the partial sum carried from below.
    always_comb begin
      sum_d              = sum_s[k];
      sum_d[k*SW +: SW]  = seg_s[SW-1:0];
    end

    // Stage register: valid bit, partial sum and segment carry.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (acc_s[k]) begin
        v_q   <= v_s[k];
        c_q   <= seg_s[SW];
        sum_q <= sum_d;
      end
    end

    assign v_s[k+1]   = v_q;
    assign c_s[k+1]   = c_q;
    assign sum_s[k+1] = sum_q;

    if (k < SEG - 1) begin : g_fwd
      logic [W-1:0] a_q;
      logic [W-1:0] b_q;

      // Carry the operands forward; upper segments and sign bits ride along.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (acc_s[k]) begin
          a_q <= a_s[k];
          b_q <= b_s[k];
        end
      end

      assign a_s[k+1] = a_q;
      assign b_s[k+1] = b_q;
    end else begin : g_last
`ifdef CPA_OVF_EN
      logic ovf_q;

      // Overflow flag built from this transaction's own sign bits.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (acc_s[k]) begin
          ovf_q <= (a_s[k][W-1] == b_s[k][W-1]) && (sum_d[W-1] != a_s[k][W-1]);
        end
      end

      assign ovf_s = ovf_q;
`else
      assign ovf_s = 1'b0;
`endif
    end
  end

  assign in_ready_o  = acc_s[0];
  assign out_valid_o = v_s[SEG];
  assign out_sum_o   = sum_s[SEG];
  assign out_cout_o  = c_s[SEG];
  assign out_ovf_o   = ovf_s;

endmodule

// File: tb/tb_cpa_pipe.sv
// Self-checking bench for cpa_pipe. Instance 0 (W=16, SEG=4) carries the
// directed scenarios; all instances take part in the randomised run.
module tb_cpa_pipe;

  localparam int NCFG  = 5;
  localparam int CFG_W   [NCFG] = '{16, 16, 16, 16, 12};
  localparam int CFG_SEG [NCFG] = '{4, 1, 2, 16, 3};
  localparam int M     = 0;
  localparam int DEPTH = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NCFG-1:0] x_valid, x_rdy, x_cin, x_ovalid, x_ordy, x_cout, x_ovf;
  logic [15:0]     x_a [NCFG];
  logic [15:0]     x_b [NCFG];
  logic [15:0]     x_sum [NCFG];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int GW = CFG_W[g];
    localparam int GS = CFG_SEG[g];
    logic [GW-1:0] sum_w;
    cpa_pipe #(.W(GW), .SEG(GS)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (x_valid[g]),
      .in_ready_o  (x_rdy[g]),
      .in_a_i      (x_a[g][GW-1:0]),
      .in_b_i      (x_b[g][GW-1:0]),
      .in_cin_i    (x_cin[g]),
      .out_valid_o (x_ovalid[g]),
      .out_ready_i (x_ordy[g]),
      .out_sum_o   (sum_w),
      .out_cout_o  (x_cout[g]),
      .out_ovf_o   (x_ovf[g])
    );
    assign x_sum[g] = 16'(sum_w);
  end

  // Reference: plain integer add of w-bit operands; returns {ovf, cout, sum}.
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
    int unsigned mask, full, s;
    logic sa, sb, ss, cout, ovf;
    mask = (32'd1 << w) - 32'd1;
    full = (32'(a) & mask) + (32'(b) & mask) + 32'(cin);
    s    = full & mask;
    cout = ((full >> w) & 32'd1) != 32'd0;
    sa   = ((32'(a) >> (w - 1)) & 32'd1) != 32'd0;
    sb   = ((32'(b) >> (w - 1)) & 32'd1) != 32'd0;
    ss   = ((s >> (w - 1)) & 32'd1) != 32'd0;
`ifdef CPA_OVF_EN
    ovf = (sa == sb) && (ss != sa);
`else
    ovf = 1'b0 & sa & sb & ss;
`endif
    return {ovf, cout, s[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (x_ovalid[M] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", x_ovalid[M]); end
    n_checks++; if (x_sum[M] !== 16'h0000) begin n_fail++; $display("FAIL reset_out_sum: got %h want 0000", x_sum[M]); end
    n_checks++; if (x_cout[M] !== 1'b0) begin n_fail++; $display("FAIL reset_out_cout: got %b want 0", x_cout[M]); end
    n_checks++; if (x_ovf[M] !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %b want 0", x_ovf[M]); end
    n_checks++; if (x_rdy[M] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", x_rdy[M]); end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    x_ordy[M]  = 1'b1;
    x_valid[M] = 1'b1;
    x_a[M] = 16'hFFFF; x_b[M] = 16'h0001; x_cin[M] = 1'b0;
    tick();
    x_valid[M] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (x_ovalid[M] !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: cycle %0d got %b want 0", i, x_ovalid[M]); end
      tick();
    end
    n_checks++; if (x_ovalid[M] !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", x_ovalid[M]); end
    n_checks++; if (x_sum[M] !== 16'h0000) begin n_fail++; $display("FAIL single_sum: got %h want 0000", x_sum[M]); end
    n_checks++; if (x_cout[M] !== 1'b1) begin n_fail++; $display("FAIL single_cout: got %b want 1", x_cout[M]); end
    n_checks++; if (x_ovf[M] !== 1'b0) begin n_fail++; $display("FAIL single_ovf: got %b want 0", x_ovf[M]); end
    tick();
    n_checks++; if (x_ovalid[M] !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got %b want 0", x_ovalid[M]); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] oa [3];
    logic [15:0] ob [3];
    logic [15:0] es [3];
    logic        ec [3];
    logic        eo [3];
    oa[0] = 16'h1234; ob[0] = 16'h1111; es[0] = 16'h2346; ec[0] = 1'b0;
    oa[1] = 16'h8000; ob[1] = 16'h8000; es[1] = 16'h0001; ec[1] = 1'b1;
    oa[2] = 16'h7FFF; ob[2] = 16'h0000; es[2] = 16'h8000; ec[2] = 1'b0;
`ifdef CPA_OVF_EN
    eo[0] = 1'b0; eo[1] = 1'b1; eo[2] = 1'b1;
`else
    eo[0] = 1'b0; eo[1] = 1'b0; eo[2] = 1'b0;
`endif
    x_ordy[M] = 1'b1;
    x_cin[M]  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x_valid[M] = 1'b1; x_a[M] = oa[i]; x_b[M] = ob[i];
      tick();
    end
    x_valid[M] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (x_ovalid[M] !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, x_ovalid[M]); end
      n_checks++; if (x_sum[M] !== es[i]) begin n_fail++; $display("FAIL b2b_sum[%0d]: got %h want %h", i, x_sum[M], es[i]); end
      n_checks++; if (x_cout[M] !== ec[i]) begin n_fail++; $display("FAIL b2b_cout[%0d]: got %b want %b", i, x_cout[M], ec[i]); end
      n_checks++; if (x_ovf[M] !== eo[i]) begin n_fail++; $display("FAIL b2b_ovf[%0d]: got %b want %b", i, x_ovf[M], eo[i]); end
    end
    tick();
    tick();
  endtask

  task automatic test_stall();
    logic [15:0] oa [6];
    logic [15:0] ob [6];
    logic        oc [6];
    logic [17:0] ex [6];
    int acc_n, emit_n;
    for (int i = 0; i < 6; i++) begin
      oa[i] = 16'($urandom); ob[i] = 16'($urandom); oc[i] = 1'($urandom);
      ex[i] = ref_add(16, oa[i], ob[i], oc[i]);
    end
    x_ordy[M] = 1'b0;
    acc_n = 0;
    for (int c = 0; c < 10; c++) begin
      x_valid[M] = (acc_n < 6);
      x_a[M] = oa[acc_n]; x_b[M] = ob[acc_n]; x_cin[M] = oc[acc_n];
      #1;
      if (x_valid[M] && x_rdy[M]) acc_n++;
      tick();
    end
    n_checks++; if (acc_n != 4) begin n_fail++; $display("FAIL stall_accepted: got %0d want 4", acc_n); end
    n_checks++; if (x_rdy[M] !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b want 0", x_rdy[M]); end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (x_ovalid[M] !== 1'b1 || {x_ovf[M], x_cout[M], x_sum[M]} !== ex[0]) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%b %h want v=1 %h", c, x_ovalid[M], {x_ovf[M], x_cout[M], x_sum[M]}, ex[0]);
      end
      tick();
    end
    x_ordy[M] = 1'b1;
    emit_n = 0;
    for (int c = 0; c < 30 && emit_n < 6; c++) begin
      x_valid[M] = (acc_n < 6);
      x_a[M] = oa[acc_n % 6]; x_b[M] = ob[acc_n % 6]; x_cin[M] = oc[acc_n % 6];
      #1;
      if (c == 0) begin
        n_checks++; if (x_rdy[M] !== 1'b1) begin n_fail++; $display("FAIL stall_drain_fill: got %b want 1", x_rdy[M]); end
      end
      if (x_ovalid[M]) begin
        n_checks++;
        if ({x_ovf[M], x_cout[M], x_sum[M]} !== ex[emit_n]) begin
          n_fail++; $display("FAIL stall_order[%0d]: got %h want %h", emit_n, {x_ovf[M], x_cout[M], x_sum[M]}, ex[emit_n]);
        end
        emit_n++;
      end
      if (x_valid[M] && x_rdy[M]) acc_n++;
      tick();
    end
    x_valid[M] = 1'b0;
    n_checks++; if (emit_n != 6 || acc_n != 6) begin n_fail++; $display("FAIL stall_total: got emit=%0d acc=%0d want 6/6", emit_n, acc_n); end
    tick();
  endtask

  task automatic test_bubble();
    logic [15:0] oa [4];
    logic [15:0] ob [4];
    logic        oc [4];
    logic [17:0] ex [4];
    int emit_n;
    for (int i = 0; i < 4; i++) begin
      oa[i] = 16'($urandom); ob[i] = 16'($urandom); oc[i] = 1'($urandom);
      ex[i] = ref_add(16, oa[i], ob[i], oc[i]);
    end
    x_ordy[M] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x_valid[M] = 1'b1; x_a[M] = oa[i]; x_b[M] = ob[i]; x_cin[M] = oc[i];
      #1;
      n_checks++; if (x_rdy[M] !== 1'b1) begin n_fail++; $display("FAIL bubble_accept[%0d]: got %b want 1", i, x_rdy[M]); end
      tick();
      x_valid[M] = 1'b0;
      if (i == 0) begin
        tick();
        tick();
      end
    end
    n_checks++; if (x_rdy[M] !== 1'b0) begin n_fail++; $display("FAIL bubble_full: got %b want 0", x_rdy[M]); end
    x_ordy[M] = 1'b1;
    emit_n = 0;
    for (int c = 0; c < 20 && emit_n < 4; c++) begin
      if (x_ovalid[M]) begin
        n_checks++;
        if ({x_ovf[M], x_cout[M], x_sum[M]} !== ex[emit_n]) begin
          n_fail++; $display("FAIL bubble_order[%0d]: got %h want %h", emit_n, {x_ovf[M], x_cout[M], x_sum[M]}, ex[emit_n]);
        end
        emit_n++;
      end
      tick();
    end
    n_checks++; if (emit_n != 4) begin n_fail++; $display("FAIL bubble_total: got %0d want 4", emit_n); end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    x_ordy[M] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x_valid[M] = 1'b1; x_a[M] = 16'($urandom) | 16'h0101; x_b[M] = 16'($urandom); x_cin[M] = 1'b1;
      tick();
    end
    x_valid[M] = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (x_ovalid[M] !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", x_ovalid[M]); end
    n_checks++; if ({x_ovf[M], x_cout[M], x_sum[M]} !== 18'h0) begin n_fail++; $display("FAIL rstmid_data: got %h want 0", {x_ovf[M], x_cout[M], x_sum[M]}); end
    n_checks++; if (x_rdy[M] !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", x_rdy[M]); end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (x_ovalid[M]) seen++;
      tick();
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_stale: got %0d results want 0", seen); end
  endtask

  task automatic test_random();
    logic [17:0] exq [NCFG][DEPTH];
    int wr [NCFG];
    int rd [NCFG];
    logic [17:0] got;
    for (int i = 0; i < NCFG; i++) begin wr[i] = 0; rd[i] = 0; end
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < NCFG; i++) begin
        x_valid[i] = (cyc < 600) && ($urandom_range(0, 3) != 0);
        x_a[i]     = 16'($urandom);
        x_b[i]     = 16'($urandom);
        x_cin[i]   = 1'($urandom);
        x_ordy[i]  = (cyc >= 600) || ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int i = 0; i < NCFG; i++) begin
        if (x_ovalid[i] && x_ordy[i]) begin
          got = {x_ovf[i], x_cout[i], x_sum[i]};
          n_checks++;
          if (rd[i] >= wr[i]) begin
            n_fail++; $display("FAIL rand_spurious cfg%0d: got %h want none", i, got);
          end else begin
            if (got !== exq[i][rd[i] % DEPTH]) begin
              n_fail++; $display("FAIL rand_result cfg%0d #%0d: got %h want %h", i, rd[i], got, exq[i][rd[i] % DEPTH]);
            end
            rd[i]++;
          end
        end
        if (x_valid[i] && x_rdy[i]) begin
          exq[i][wr[i] % DEPTH] = ref_add(CFG_W[i], x_a[i], x_b[i], x_cin[i]);
          wr[i]++;
        end
      end
      tick();
    end
    for (int i = 0; i < NCFG; i++) begin
      n_checks++;
      if (rd[i] != wr[i] || wr[i] == 0) begin
        n_fail++; $display("FAIL rand_drain cfg%0d: got %0d emitted want %0d", i, rd[i], wr[i]);
      end
    end
  endtask

  initial begin
    x_valid = '0; x_cin = '0; x_ordy = '0;
    for (int i = 0; i < NCFG; i++) begin x_a[i] = 16'h0000; x_b[i] = 16'h0000; end
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_bubble();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
